video_serializer: RTL and testbench



---
 rtl/video_pkg.sv | 41 ++++
 rtl/video_serializer_byte_fifo.sv | 77 +++++++
 rtl/video_serializer.sv | 135 +++++++++++++
 tb/tb_video_serializer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and the byte-to-pen bit mapping for the video serializer.
package video_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } mode_e;

    localparam int BORDER_PEN = 16;

    // Pen number for the pixel at slot phase p of screen byte b in the given mode.
    function automatic logic [3:0] pen_of(input logic [7:0] b, input mode_e mode,
                                          input logic [2:0] p);
        logic [3:0] pen;
        logic [2:0] k;
        pen = 4'd0;
        k   = 3'd0;
        unique case (mode)
            MODE2: begin
                k   = p;
                pen = {3'b000, b[3'd7 - k]};
            end
            MODE1: begin
                k   = {1'b0, p[2:1]};
                pen = {2'b00, b[3'd3 - k], b[3'd7 - k]};
            end
            default: begin
                k   = {2'b00, p[2]};
                pen = {b[3'd1 - k], b[3'd5 - k], b[3'd3 - k], b[3'd7 - k]};
                // Mode 3 is the 4-pen variant of the mode 0 layout.
                if (mode == MODE3) begin
                    pen[3:2] = 2'b00;
                end
            end
        endcase
        return pen;
    endfunction

endpackage

// File: rtl/video_serializer_byte_fifo.sv
// Small power-of-two FIFO with registered full/empty flags.
module byte_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    // Accept/pointer/count bookkeeping; a full FIFO refuses even when popping.
    always_comb begin
        push_ok  = push && !full_q;
        pop_ok   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (AW + 1)'(1);
        end
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/video_serializer.sv
// Pixel serializer: byte FIFO, slot phase, mode latch, palette lookup.
module video_serializer
    import video_pkg::*;
#(
    parameter int COLOUR_W   = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cen_16,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                in_dispen,
    input  logic [1:0]          mode_req,
    input  logic                pal_we,
    input  logic [4:0]          pal_addr,
    input  logic [COLOUR_W-1:0] pal_data,
    input  logic                force_blank,
    output logic [COLOUR_W-1:0] colour,
    output logic                border_out,
    output logic                underrun,
    output logic [1:0]          mode_cur
);

    localparam int PAL_N = BORDER_PEN + 1;

    logic [2:0]          ph_q, ph_d;
    logic [7:0]          cur_byte_q, cur_byte_d;
    logic                cur_dispen_q, cur_dispen_d;
    mode_e               mode_q, mode_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                border_q, border_d;
    logic                underrun_q, underrun_d;
    logic [COLOUR_W-1:0] pal_q [PAL_N];
    logic [COLOUR_W-1:0] pal_d [PAL_N];

    logic                slot_end;
    logic                fifo_full, fifo_empty;
    logic [8:0]          fifo_rdata;
    logic [3:0]          pen;

    assign slot_end = cen_16 && (ph_q == 3'd7);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (slot_end),
        .wdata ({in_dispen, in_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Slot phase, byte/mode load at the slot boundary and palette writes.
    always_comb begin
        ph_d         = ph_q;
        cur_byte_d   = cur_byte_q;
        cur_dispen_d = cur_dispen_q;
        mode_d       = mode_q;
        underrun_d   = 1'b0;
        pal_d        = pal_q;
        if (cen_16) begin
            ph_d = ph_q + 3'd1;
        end
        if (slot_end) begin
            mode_d = mode_e'(mode_req);
            if (fifo_empty) begin
                cur_dispen_d = 1'b0;
                underrun_d   = 1'b1;
            end else begin
                cur_byte_d   = fifo_rdata[7:0];
                cur_dispen_d = fifo_rdata[8];
            end
        end
        if (pal_we && (pal_addr <= 5'(BORDER_PEN))) begin
            pal_d[pal_addr] = pal_data;
        end
    end

    // Colour resolution: blank beats border beats the byte's pen.
    always_comb begin
        pen      = pen_of(cur_byte_q, mode_q, ph_q);
        colour_d = colour_q;
        border_d = border_q;
        if (cen_16) begin
            if (force_blank) begin
                colour_d = '0;
                border_d = 1'b0;
            end else if (!cur_dispen_q) begin
                colour_d = pal_q[BORDER_PEN];
                border_d = 1'b1;
            end else begin
                colour_d = pal_q[{1'b0, pen}];
                border_d = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q         <= 3'd0;
            cur_byte_q   <= 8'd0;
            cur_dispen_q <= 1'b0;
            mode_q       <= MODE0;
            colour_q     <= '0;
            border_q     <= 1'b0;
            underrun_q   <= 1'b0;
            for (int i = 0; i < PAL_N; i++) begin
                pal_q[i] <= '0;
            end
        end else begin
            ph_q         <= ph_d;
            cur_byte_q   <= cur_byte_d;
            cur_dispen_q <= cur_dispen_d;
            mode_q       <= mode_d;
            colour_q     <= colour_d;
            border_q     <= border_d;
            underrun_q   <= underrun_d;
            pal_q        <= pal_d;
        end
    end

    assign in_ready   = !fifo_full;
    assign colour     = colour_q;
    assign border_out = border_q;
    assign underrun   = underrun_q;
    assign mode_cur   = mode_q;

endmodule

// File: tb/tb_video_serializer.sv
// Directed self-checking bench for video_serializer.
module tb_video_serializer;

    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cen_16 = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'd0;
    logic          in_dispen = 1'b0;
    logic [1:0]    mode_req = 2'd0;
    logic          pal_we = 1'b0;
    logic [4:0]    pal_addr = 5'd0;
    logic [CW-1:0] pal_data = '0;
    logic          force_blank = 1'b0;
    logic [CW-1:0] colour;
    logic          border_out;
    logic          underrun;
    logic [1:0]    mode_cur;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ph   = 0;

    logic [CW-1:0] s_colour, s_colour2;
    logic          s_border, s_under, s_under2, s_ready;
    logic [1:0]    s_mode;

    video_serializer #(.COLOUR_W(CW), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen_16      (cen_16),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_dispen   (in_dispen),
        .mode_req    (mode_req),
        .pal_we      (pal_we),
        .pal_addr    (pal_addr),
        .pal_data    (pal_data),
        .force_blank (force_blank),
        .colour      (colour),
        .border_out  (border_out),
        .underrun    (underrun),
        .mode_cur    (mode_cur)
    );

    always #5 clk = ~clk;

    // One cen edge, sampled half a clock later, then one idle clock (sampled again).
    task automatic do_cen();
        @(negedge clk);
        cen_16 = 1'b1;
        @(negedge clk);
        cen_16    = 1'b0;
        s_colour  = colour;
        s_border  = border_out;
        s_under   = underrun;
        s_mode    = mode_cur;
        s_ready   = in_ready;
        @(negedge clk);
        s_colour2 = colour;
        s_under2  = underrun;
        exp_ph    = (exp_ph + 1) % 8;
    endtask

    task automatic push(input logic [7:0] d, input logic de);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_dispen = de;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic pal_write(input logic [4:0] a, input logic [CW-1:0] d);
        @(negedge clk);
        pal_we   = 1'b1;
        pal_addr = a;
        pal_data = d;
        @(negedge clk);
        pal_we   = 1'b0;
    endtask

    // Runs cen edges up to and including the next slot-boundary (ph==7) edge.
    task automatic run_to_boundary();
        while (exp_ph != 7) do_cen();
        do_cen();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({colour, border_out, underrun, mode_cur, in_ready} !== {5'd0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: colour=%h border=%b underrun=%b mode=%0d ready=%b, want 00 0 0 0 1",
                     colour, border_out, underrun, mode_cur, in_ready);
        end
        rst_n  = 1'b1;
        exp_ph = 0;
        for (int i = 1; i <= 16; i++) begin
            do_cen();
            n_checks++;
            if (s_under !== (i % 8 == 0)) begin
                n_fail++;
                $display("FAIL reset_underrun cen %0d: got %b want %b", i, s_under, (i % 8 == 0));
            end
            n_checks++;
            if ({s_colour, s_border} !== {5'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_border cen %0d: colour=%h border=%b want 00 1", i, s_colour, s_border);
            end
            if (i == 8) begin
                n_checks++;
                if (s_under2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL underrun_pulse_width: got %b a clk later, want 0", s_under2);
                end
            end
        end
    endtask

    task automatic test_mode2();
        logic [CW-1:0] exp_c [8];
        exp_c = '{5'h0A, 5'h04, 5'h0A, 5'h04, 5'h04, 5'h0A, 5'h04, 5'h0A};
        mode_req = 2'd2;
        pal_write(5'd0, 5'h04);
        pal_write(5'd1, 5'h0A);
        push(8'hA5, 1'b1);
        run_to_boundary();
        n_checks++;
        if (s_mode !== 2'd2) begin
            n_fail++;
            $display("FAIL mode2_latch: mode_cur=%0d want 2", s_mode);
        end
        for (int i = 0; i < 8; i++) begin
            do_cen();
            n_checks++;
            if ({s_colour, s_border} !== {exp_c[i], 1'b0}) begin
                n_fail++;
                $display("FAIL mode2_pixel %0d: colour=%h border=%b want %h 0", i, s_colour, s_border, exp_c[i]);
            end
            if (i == 3) begin
                n_checks++;
                if (s_colour2 !== exp_c[3]) begin
                    n_fail++;
                    $display("FAIL colour_hold: colour=%h between cen, want %h", s_colour2, exp_c[3]);
                end
            end
        end
    endtask

    task automatic test_mode0();
        mode_req = 2'd0;
        pal_write(5'd9, 5'h13);
        pal_write(5'd6, 5'h1C);
        push(8'h96, 1'b1);
        run_to_boundary();
        for (int i = 0; i < 8; i++) begin
            do_cen();
            n_checks++;
            if ({s_colour, s_mode} !== {((i < 4) ? 5'h13 : 5'h1C), 2'd0}) begin
                n_fail++;
                $display("FAIL mode0_pixel %0d: colour=%h mode=%0d want %h 0", i, s_colour, s_mode,
                         ((i < 4) ? 5'h13 : 5'h1C));
            end
        end
    endtask

    task automatic test_mode_change();
        logic [CW-1:0] exp_c [8];
        exp_c = '{5'h15, 5'h15, 5'h0A, 5'h0A, 5'h15, 5'h15, 5'h0A, 5'h0A};
        mode_req = 2'd2;
        pal_write(5'd2, 5'h15);
        push(8'hF0, 1'b1);
        push(8'h5A, 1'b1);
        run_to_boundary();
        for (int i = 0; i < 8; i++) begin
            if (exp_ph == 3) mode_req = 2'd1;
            do_cen();
            n_checks++;
            if ({s_colour, s_mode} !== {((i < 4) ? 5'h0A : 5'h04), ((i == 7) ? 2'd1 : 2'd2)}) begin
                n_fail++;
                $display("FAIL modechg_first_byte %0d: colour=%h mode=%0d want %h %0d", i, s_colour, s_mode,
                         ((i < 4) ? 5'h0A : 5'h04), ((i == 7) ? 1 : 2));
            end
        end
        for (int i = 0; i < 8; i++) begin
            do_cen();
            n_checks++;
            if (s_colour !== exp_c[i]) begin
                n_fail++;
                $display("FAIL modechg_mode1_pixel %0d: colour=%h want %h", i, s_colour, exp_c[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [2];
        bytes    = '{8'h80, 8'h40};
        mode_req = 2'd2;
        push(8'h80, 1'b1);
        push(8'h40, 1'b1);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_full_ready: in_ready=%b want 0", in_ready);
        end
        push(8'h20, 1'b1);
        while (exp_ph != 7) do_cen();
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_pop: in_ready=%b want 0", s_ready);
        end
        do_cen();
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_pop: in_ready=%b want 1", s_ready);
        end
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 8; i++) begin
                do_cen();
                n_checks++;
                if (s_colour !== (bytes[b][7 - i] ? 5'h0A : 5'h04)) begin
                    n_fail++;
                    $display("FAIL order byte %0d pixel %0d: colour=%h want %h", b, i, s_colour,
                             (bytes[b][7 - i] ? 5'h0A : 5'h04));
                end
            end
        end
        n_checks++;
        if (s_under !== 1'b1) begin
            n_fail++;
            $display("FAIL refused_push_underrun: underrun=%b want 1", s_under);
        end
        do_cen();
        n_checks++;
        if ({s_colour, s_border} !== {5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL underrun_border: colour=%h border=%b want 00 1", s_colour, s_border);
        end
    endtask

    task automatic test_border_blank_reset();
        mode_req = 2'd3;
        pal_write(5'd16, 5'h07);
        push(8'hFF, 1'b0);
        run_to_boundary();
        for (int i = 0; i < 4; i++) begin
            do_cen();
            n_checks++;
            if ({s_colour, s_border} !== {5'h07, 1'b1}) begin
                n_fail++;
                $display("FAIL border_slot %0d: colour=%h border=%b want 07 1", i, s_colour, s_border);
            end
        end
        pal_write(5'd16, 5'h19);
        do_cen();
        n_checks++;
        if ({s_colour, s_border} !== {5'h19, 1'b1}) begin
            n_fail++;
            $display("FAIL border_pal_update: colour=%h border=%b want 19 1", s_colour, s_border);
        end
        force_blank = 1'b1;
        do_cen();
        force_blank = 1'b0;
        n_checks++;
        if ({s_colour, s_border} !== {5'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL force_blank: colour=%h border=%b want 00 0", s_colour, s_border);
        end
        do_cen();
        n_checks++;
        if ({s_colour, s_border} !== {5'h19, 1'b1}) begin
            n_fail++;
            $display("FAIL blank_release: colour=%h border=%b want 19 1", s_colour, s_border);
        end
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        while (exp_ph != 5) do_cen();
        push(8'h33, 1'b0);
        n_checks++;
        if ({mode_cur, in_ready, colour, border_out} !== {2'd3, 1'b0, 5'h19, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset_state: mode=%0d ready=%b colour=%h border=%b want 3 0 19 1",
                     mode_cur, in_ready, colour, border_out);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({colour, border_out, underrun, mode_cur, in_ready} !== {5'd0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: colour=%h border=%b underrun=%b mode=%0d ready=%b, want 00 0 0 0 1",
                     colour, border_out, underrun, mode_cur, in_ready);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        exp_ph   = 0;
        mode_req = 2'd0;
        for (int i = 1; i <= 8; i++) begin
            do_cen();
            n_checks++;
            if ({s_under, s_colour, s_border} !== {(i == 8), 5'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL post_reset cen %0d: underrun=%b colour=%h border=%b want %b 00 1",
                         i, s_under, s_colour, s_border, (i == 8));
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode2();
        test_mode0();
        test_mode_change();
        test_back_to_back();
        test_border_blank_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
